// File: rtl/pll_reconfig_seq.sv
// Sequences Avalon-MM writes into the PLL reconfig core (mode, M, C0, C1, start),
// polls status, then waits for a stable synchronised lock before reporting done/err.
module pll_reconfig_seq #(
  parameter int C0_IDX      = 0,
  parameter int C1_IDX      = 1,
  parameter int LOCK_STABLE = 16,
  parameter int TIMEOUT     = 1048575
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [4:0] C0_SEL = 5'(C0_IDX);
  localparam logic [4:0] C1_SEL = 5'(C1_IDX);

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_M, WR_C0, WR_C1, WR_START, RD_STATUS, WAIT_LOCK, DONE, ERR
  } state_t;

  state_t state, state_n, wr_next;
  logic        gap, gap_n;
  logic [17:0] m_q, c0_q, c1_q;
  logic [1:0]  lock_sync;
  logic        lock_s, status_ok, tmo_hit, is_wr, in_wait;
  logic [SW-1:0] stable;
  logic [19:0] tmo;
  logic        unused_rd;

  assign lock_s    = lock_sync[1];
  assign is_wr     = state inside {WR_MODE, WR_M, WR_C0, WR_C1, WR_START};
  assign in_wait   = (state == RD_STATUS) || (state == WAIT_LOCK);
  assign tmo_hit   = (tmo == 20'(TIMEOUT - 1));
  assign cfg_busy  = (state != IDLE);
  assign unused_rd = ^mgmt_readdata[31:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap       <= 1'b0;
      lock_sync <= 2'b00;
      m_q       <= '0;
      c0_q      <= '0;
      c1_q      <= '0;
      status_ok <= 1'b0;
      stable    <= '0;
      tmo       <= '0;
    end else begin
      state     <= state_n;
      gap       <= gap_n;
      lock_sync <= {lock_sync[0], pll_locked};
      if (state == IDLE && cfg_req) begin
        m_q  <= cfg_m;
        c0_q <= cfg_c0;
        c1_q <= cfg_c1;
      end
      if (state == RD_STATUS && !gap && !mgmt_waitrequest)
        status_ok <= mgmt_readdata[0];
      // run length of synced lock; any drop restarts the count
      if (state == WAIT_LOCK && lock_s) stable <= stable + SW'(1);
      else                              stable <= '0;
      // budget covers both the status poll and the lock wait
      if (in_wait) tmo <= tmo + 20'd1;
      else         tmo <= '0;
    end
  end

  always_comb begin
    state_n        = state;
    gap_n          = gap;
    wr_next        = IDLE;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    cfg_done       = 1'b0;
    cfg_err        = 1'b0;
    case (state)
      IDLE: if (cfg_req) begin
        state_n = WR_MODE;
        gap_n   = 1'b0;
      end
      WR_MODE: begin
        mgmt_address = 6'h00; mgmt_writedata = 32'd1; wr_next = WR_M;
      end
      WR_M: begin
        mgmt_address = 6'h04; mgmt_writedata = {14'b0, m_q}; wr_next = WR_C0;
      end
      WR_C0: begin
        mgmt_address = 6'h05; mgmt_writedata = {9'b0, C0_SEL, c0_q}; wr_next = WR_C1;
      end
      WR_C1: begin
        mgmt_address = 6'h05; mgmt_writedata = {9'b0, C1_SEL, c1_q}; wr_next = WR_START;
      end
      WR_START: begin
        mgmt_address = 6'h02; mgmt_writedata = 32'd1; wr_next = RD_STATUS;
      end
      RD_STATUS: begin
        mgmt_address = 6'h01;
        if (!gap) begin
          mgmt_read = 1'b1;
          if (!mgmt_waitrequest) gap_n = 1'b1;
        end else begin
          gap_n = 1'b0;
          if (status_ok) state_n = WAIT_LOCK;
        end
      end
      WAIT_LOCK: if (lock_s && stable == SW'(LOCK_STABLE - 1)) state_n = DONE;
      DONE: begin cfg_done = 1'b1; state_n = IDLE; end
      ERR:  begin cfg_err  = 1'b1; state_n = IDLE; end
      default: state_n = IDLE;
    endcase
    // every transfer is a strobe phase held through waitrequest, then one idle gap cycle
    if (is_wr) begin
      if (!gap) begin
        mgmt_write = 1'b1;
        if (!mgmt_waitrequest) gap_n = 1'b1;
      end else begin
        gap_n   = 1'b0;
        state_n = wr_next;
      end
    end
    if (in_wait && tmo_hit) begin
      state_n = ERR;
      gap_n   = 1'b0;
    end
  end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed + randomized bench: a reactive Avalon responder, and a window-level model
// of transfer durations and lock run-length that predicts the done/err cycle.
module tb_pll_reconfig_seq;
  localparam int TMO = 1000;
  localparam int LS  = 16;

  logic        clk = 1'b0, rst = 1'b1, cfg_req = 1'b0;
  logic [17:0] cfg_m = '0, cfg_c0 = '0, cfg_c1 = '0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic        pll_locked = 1'b1;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = '0;
  logic        mgmt_waitrequest = 1'b0;

  always #5 clk = ~clk;

  pll_reconfig_seq #(.C0_IDX(0), .C1_IDX(1), .LOCK_STABLE(LS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest));

  int n_cmp = 0, n_bad = 0;
  int sw = 0, sr = 0, nr = 0, rdn = 0, cnt = 0, glitch = -1;
  bit never = 1'b0, prev_cmp = 1'b0;
  logic [37:0] wlog[$];
  logic [47:0] held;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // raw lock level driven during window n (window 0 = request cycle)
  function automatic bit lock_at(input int n);
    if (never) return 1'b0;
    if (n == glitch) return 1'b0;
    return 1'b1;
  endfunction

  // window of the done/err pulse: each transfer costs 2+stall windows, lock is seen
  // two windows late, done needs LS consecutive locked windows after the last read
  function automatic int model_end(input int s_w, input int s_r, input int n_r, output bit e);
    int r, w;
    bit ok;
    r = 1 + 5 * (2 + s_w);
    w = r + (n_r + 1) * (2 + s_r);
    e = 1'b0;
    for (int p = w + LS; p < r + TMO; p++) begin
      ok = 1'b1;
      for (int q = p - LS; q < p; q++) if (!lock_at(q - 2)) ok = 1'b0;
      if (ok) return p;
    end
    e = 1'b1;
    return r + TMO;
  endfunction

  // Avalon slave: stalls each strobe, logs completed writes, checks hold and gap rules
  always @(negedge clk) begin
    if (rst) begin
      mgmt_waitrequest = 1'b0; cnt = 0; prev_cmp = 1'b0;
    end else begin
      if (prev_cmp) chk("strobe_gap", {46'b0, mgmt_write, mgmt_read}, 48'd0);
      prev_cmp = 1'b0;
      if (mgmt_write || mgmt_read) begin
        if (cnt > 0)
          chk("stall_hold", {8'b0, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, held);
        held = {8'b0, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
        if (cnt < (mgmt_read ? sr : sw)) begin
          mgmt_waitrequest = 1'b1; cnt++;
        end else begin
          mgmt_waitrequest = 1'b0; cnt = 0; prev_cmp = 1'b1;
          if (mgmt_read) begin
            mgmt_readdata = ($urandom() & 32'hFFFF_FFFE) | 32'(rdn >= nr);
            rdn++;
          end else wlog.push_back({mgmt_address, mgmt_writedata});
        end
      end else begin
        mgmt_waitrequest = 1'b0; cnt = 0;
      end
    end
  end

  // one request from IDLE; called and returns on a negedge
  task automatic run(input string tag, input logic [17:0] m, input logic [17:0] c0,
                     input logic [17:0] c1, input int s_w, input int s_r, input int n_r,
                     input int g, input bit nv, output int end_n);
    logic [37:0] exp_w[$];
    bit exp_e, got_e;
    int exp_n;
    sw = s_w; sr = s_r; nr = n_r; rdn = 0; glitch = g; never = nv;
    wlog.delete();
    exp_n = model_end(s_w, s_r, n_r, exp_e);
    exp_w = '{{6'h00, 32'd1}, {6'h04, {14'b0, m}}, {6'h05, {9'b0, 5'd0, c0}},
              {6'h05, {9'b0, 5'd1, c1}}, {6'h02, 32'd1}};
    cfg_m = m; cfg_c0 = c0; cfg_c1 = c1; cfg_req = 1'b1; pll_locked = lock_at(0);
    end_n = -1; got_e = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      cfg_req = 1'b0; pll_locked = lock_at(n);
      if (cfg_done || cfg_err) begin
        end_n = n; got_e = cfg_err;
        chk({tag, "_excl"}, {46'b0, cfg_done, cfg_err}, {46'b0, ~exp_e, exp_e});
        break;
      end
      chk({tag, "_busy"}, 48'(cfg_busy), 48'd1);
    end
    chk({tag, "_end"}, 48'(end_n), 48'(exp_n));
    chk({tag, "_err"}, 48'(got_e), 48'(exp_e));
    chk({tag, "_nwr"}, 48'(wlog.size()), 48'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) chk({tag, "_wr"}, 48'(wlog[i]), 48'(exp_w[i]));
    @(negedge clk);
    chk({tag, "_idle"}, {45'b0, cfg_busy, cfg_done, cfg_err}, 48'd0);
  endtask

  initial begin
    int e, w;
    bit ok;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out", {cfg_busy, cfg_done, cfg_err, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, 48'd0);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({cfg_busy, cfg_done, cfg_err, mgmt_write, mgmt_read} != 5'd0) ok = 1'b0;
    end
    chk("idle_100", 48'(ok), 48'd1);

    // basic: expect done in the 30th cycle counting the request cycle as the first
    run("basic", 18'h20B0A, 18'h00505, 18'h01919, 0, 0, 0, -1, 1'b0, e);
    chk("basic_30", 48'(e + 1), 48'd30);
    // 3-cycle stalls on every write push done out by 15 cycles
    run("stall", 18'h20B0A, 18'h00505, 18'h01919, 3, 0, 0, -1, 1'b0, e);
    chk("stall_45", 48'(e + 1), 48'd45);
    // lock drop seen while stable count is 10 (wait starts window 13)
    run("glitch", 18'h1ABCD, 18'h0F00F, 18'h30303, 0, 0, 0, 13 + 8, 1'b0, e);
    chk("glitch_lat", 48'(e), 48'd40);
    run("notready", 18'h00102, 18'h00203, 18'h00304, 1, 2, 2, -1, 1'b0, e);

    for (int k = 0; k < 8; k++) begin
      int s_w, s_r, n_r, g;
      s_w = $urandom_range(0, 4); s_r = $urandom_range(0, 3); n_r = $urandom_range(0, 3);
      w = 1 + 5 * (2 + s_w) + (n_r + 1) * (2 + s_r);
      g = ($urandom_range(0, 1) == 0) ? -1 : w + $urandom_range(0, 20) - 2;
      run("rand", 18'($urandom()), 18'($urandom()), 18'($urandom()), s_w, s_r, n_r, g, 1'b0, e);
    end

    // lock never asserts: err after TMO cycles of poll + wait
    never = 1'b1; pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    run("timeout", 18'h20B0A, 18'h00505, 18'h01919, 0, 0, 0, -1, 1'b1, e);
    chk("timeout_lat", 48'(e), 48'(11 + TMO));
    never = 1'b0; pll_locked = 1'b1;
    repeat (4) @(negedge clk);

    // reset while WR_C0 is stalled
    sw = 50; sr = 0; nr = 0; rdn = 0; glitch = -1;
    cfg_m = 18'h11111; cfg_c0 = 18'h22222; cfg_c1 = 18'h33333; cfg_req = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      cfg_req = 1'b0;
      if (mgmt_write && mgmt_address == 6'h05) ok = 1'b1;
    end
    chk("reach_c0", 48'(ok), 48'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", {45'b0, mgmt_write, mgmt_read, cfg_busy}, 48'd0);
    @(negedge clk);
    chk("rst_hold", {cfg_busy, cfg_done, cfg_err, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, 48'd0);
    rst = 1'b0;
    @(negedge clk);
    run("after_rst", 18'h20B0A, 18'h00505, 18'h01919, 0, 0, 0, -1, 1'b0, e);
    chk("after_rst_30", 48'(e + 1), 48'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
